// File: rtl/instruction_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the instruction loader slice.
//   state_t            : loader FSM states (IDLE, RECV, WRITE, DONE, ERROR)
//   HALT_INSTR_DEFAULT : end-of-program marker written as the last word
//   BYTES_PER_WORD     : bytes assembled into one instruction
//   ADDR_STEP          : byte-address increment between instruction words
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD     = 4;
    localparam int          ADDR_STEP          = 4;

endpackage

// File: rtl/instruction_loader_if.sv
// ---------------------------------------------------------------------------
// instruction_loader_if
// Groups the byte stream from the UART receiver and the instruction-memory
// write port of the fetch stage.
//   i_rx_data / i_rx_valid : received byte and its one-cycle strobe
//   o_instruction_address  : byte address of the word being written
//   o_instruction          : assembled big-endian instruction word
//   o_flag_write_intruc    : one-cycle write strobe to instruction memory
// Modports:
//   master : the loader (consumes bytes, drives the write port)
//   slave  : the environment (UART side drives bytes, memory observes writes)
// Handshake: there is no back-pressure. A byte is transferred on every rising
// clock edge where i_rx_valid is high; a word is written on every rising edge
// where o_flag_write_intruc is high, with address and data stable for that
// whole cycle.
// ---------------------------------------------------------------------------
interface instruction_loader_if #(
    parameter int BITS_SIZE = 32
);
    logic [7:0]           i_rx_data;
    logic                 i_rx_valid;
    logic [BITS_SIZE-1:0] o_instruction_address;
    logic [BITS_SIZE-1:0] o_instruction;
    logic                 o_flag_write_intruc;

    modport master (
        input  i_rx_data,
        input  i_rx_valid,
        output o_instruction_address,
        output o_instruction,
        output o_flag_write_intruc
    );

    modport slave (
        output i_rx_data,
        output i_rx_valid,
        input  o_instruction_address,
        input  o_instruction,
        input  o_flag_write_intruc
    );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Shifts bytes in big-endian order (first byte ends up in the top byte) and
// counts them modulo BYTES_PER_WORD.
// Ports:
//   i_clk, i_reset    : clock, asynchronous active-low reset
//   i_clear           : synchronous clear of shift register and byte counter
//   i_byte_valid      : accept i_byte this cycle
//   i_byte            : byte to shift in
//   o_word            : current shift-register contents
//   o_word_ready      : combinational pulse when the accepted byte completes a word
// ---------------------------------------------------------------------------
module word_assembler
    import loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_ready
);

    logic [1:0] byte_cnt;

    assign o_word_ready = i_byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    // The counter wraps after the 4th byte, so a byte accepted in the write
    // cycle naturally becomes byte 0 of the next word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_word   <= '0;
            byte_cnt <= '0;
        end else if (i_clear) begin
            o_word   <= '0;
            byte_cnt <= '0;
        end else if (i_byte_valid) begin
            o_word   <= {o_word[WIDTH-9:0], i_byte};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
// Fills instruction memory from a UART byte stream before the pipeline runs.
// Bytes are assembled big-endian into words and written one word at a time.
// Loading ends after the HALT word is written (DONE) or when the last memory
// word is written without HALT (ERROR, overflow).
// Optional feature macro: LOADER_TIMEOUT_EN -- when defined, a stalled byte
// stream in RECV for TIMEOUT_CYCLES cycles aborts the load with o_timeout_err.
// Ports:
//   i_clk, i_reset   : clock, asynchronous active-low reset
//   i_start          : one-cycle pulse; starts a load from IDLE/DONE/ERROR
//   bus (master)     : byte stream in, instruction-memory write port out
//   o_busy           : high while in RECV or WRITE
//   o_load_done      : HALT written (sticky until start/reset)
//   o_overflow_err   : memory filled without HALT (sticky until start/reset)
//   o_timeout_err    : stalled stream (constant 0 without the macro)
//   o_word_count     : words written in the current load
//   o_state          : current FSM state, for debug/observation
// ---------------------------------------------------------------------------
module instruction_loader
    import loader_pkg::*;
#(
    parameter int                   BITS_SIZE      = 32,
    parameter int                   SIZE_TOTAL     = 256,
    parameter logic [BITS_SIZE-1:0] HALT_INSTR     = BITS_SIZE'(HALT_INSTR_DEFAULT),
    parameter int                   TIMEOUT_CYCLES = 1000000,
    localparam int                  WC_W           = $clog2(SIZE_TOTAL / 4) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    instruction_loader_if.master bus,
    output logic                 o_busy,
    output logic                 o_load_done,
    output logic                 o_overflow_err,
    output logic                 o_timeout_err,
    output logic [WC_W-1:0]      o_word_count,
    output state_t               o_state
);

    localparam logic [BITS_SIZE-1:0] LAST_ADDR = BITS_SIZE'(SIZE_TOTAL - ADDR_STEP);

    state_t               state, next_state;
    logic [BITS_SIZE-1:0] addr_q;
    logic [BITS_SIZE-1:0] word;
    logic                 word_ready;
    logic                 flag_q;
    logic                 start_ok;
    logic                 is_halt;
    logic                 last_slot;
    logic                 write_continues;
    logic                 byte_accept;
    logic                 timeout_hit;

    assign start_ok        = i_start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign is_halt         = (word == HALT_INSTR);
    assign last_slot       = (addr_q == LAST_ADDR);
    // Decided from registered word/address only, so byte acceptance in the
    // WRITE cycle does not depend on next_state (no combinational loop).
    assign write_continues = !is_halt && !last_slot;
    assign byte_accept     = bus.i_rx_valid &&
                             ((state == RECV) || ((state == WRITE) && write_continues));

    word_assembler #(
        .WIDTH (BITS_SIZE)
    ) u_asm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (start_ok || timeout_hit),
        .i_byte_valid (byte_accept),
        .i_byte       (bus.i_rx_data),
        .o_word       (word),
        .o_word_ready (word_ready)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_err_q;

    assign timeout_hit   = (state == RECV) && !bus.i_rx_valid &&
                           (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign o_timeout_err = tmo_err_q;

    // Counts idle RECV cycles; any byte or leaving RECV restarts the count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if ((state != RECV) || bus.i_rx_valid) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (start_ok) begin
                tmo_err_q <= 1'b0;
            end else if (timeout_hit) begin
                tmo_err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign o_timeout_err      = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start_ok) next_state = RECV;
            end
            RECV: begin
                if (word_ready)       next_state = WRITE;
                else if (timeout_hit) next_state = ERROR;
            end
            WRITE: begin
                if (is_halt)        next_state = DONE;
                else if (last_slot) next_state = ERROR;
                else                next_state = RECV;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            flag_q         <= 1'b0;
            o_busy         <= 1'b0;
            o_load_done    <= 1'b0;
            o_overflow_err <= 1'b0;
            o_word_count   <= '0;
        end else begin
            state  <= next_state;
            flag_q <= (next_state == WRITE);
            o_busy <= (next_state == RECV) || (next_state == WRITE);
            if (start_ok) begin
                addr_q         <= '0;
                o_word_count   <= '0;
                o_load_done    <= 1'b0;
                o_overflow_err <= 1'b0;
            end else if (state == WRITE) begin
                o_word_count <= o_word_count + WC_W'(1);
                if (write_continues) addr_q         <= addr_q + BITS_SIZE'(ADDR_STEP);
                if (is_halt)         o_load_done    <= 1'b1;
                else if (last_slot)  o_overflow_err <= 1'b1;
            end
        end
    end

    assign bus.o_instruction_address = addr_q;
    assign bus.o_instruction         = word;
    assign bus.o_flag_write_intruc   = flag_q;
    assign o_state                   = state;

endmodule

// File: tb/tb_instruction_loader.sv
// ---------------------------------------------------------------------------
// tb_instruction_loader
// dut_a: default build (256-byte memory). dut_b: 16-byte memory and a 50-cycle
// stall limit, used for the overflow and stalled-stream scenarios.
// Expected writes ({address, word}) are queued when bytes are driven and
// popped by a per-DUT monitor whenever the write strobe is seen.
// ---------------------------------------------------------------------------
module tb_instruction_loader;
    import loader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b;

    instruction_loader_if #(.BITS_SIZE(32)) bus_a ();
    instruction_loader_if #(.BITS_SIZE(32)) bus_b ();

    logic       busy_a, done_a, ovf_a, tmo_a;
    logic [6:0] wc_a;
    state_t     st_a;
    logic       busy_b, done_b, ovf_b, tmo_b;
    logic [2:0] wc_b;
    state_t     st_b;

    instruction_loader #(.BITS_SIZE(32)) dut_a (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_start        (start_a),
        .bus            (bus_a),
        .o_busy         (busy_a),
        .o_load_done    (done_a),
        .o_overflow_err (ovf_a),
        .o_timeout_err  (tmo_a),
        .o_word_count   (wc_a),
        .o_state        (st_a)
    );

    instruction_loader #(.BITS_SIZE(32), .SIZE_TOTAL(16), .TIMEOUT_CYCLES(50)) dut_b (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_start        (start_b),
        .bus            (bus_b),
        .o_busy         (busy_b),
        .o_load_done    (done_b),
        .o_overflow_err (ovf_b),
        .o_timeout_err  (tmo_b),
        .o_word_count   (wc_b),
        .o_state        (st_b)
    );

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];
    int          cyc = 0;
    bit          spacing_en = 1'b0;
    bit          have_last  = 1'b0;
    int          last_cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (bus_a.o_flag_write_intruc === 1'b1) begin
            if (exp_a_q.size() == 0) begin
                check("a_extra_write", 64'(exp_a_q.size()), 64'd1);
            end else begin
                check("a_write", {bus_a.o_instruction_address, bus_a.o_instruction},
                      exp_a_q.pop_front());
            end
            if (spacing_en) begin
                if (have_last) check("a_strobe_gap", 64'(cyc - last_cyc), 64'd4);
                have_last = 1'b1;
                last_cyc  = cyc;
            end
        end
        if (bus_b.o_flag_write_intruc === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                check("b_extra_write", 64'(exp_b_q.size()), 64'd1);
            end else begin
                check("b_write", {bus_b.o_instruction_address, bus_b.o_instruction},
                      exp_b_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
        if (sel == 1'b0) begin
            bus_a.i_rx_data  = b;
            bus_a.i_rx_valid = 1'b1;
        end else begin
            bus_b.i_rx_data  = b;
            bus_b.i_rx_valid = 1'b1;
        end
        sync();
        bus_a.i_rx_valid = 1'b0;
        bus_b.i_rx_valid = 1'b0;
        repeat (gap) sync();
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input logic [31:0] addr,
                             input int gap, input bit expect_write);
        logic [31:0] wv;
        wv = w;
        if (expect_write) begin
            if (sel == 1'b0) exp_a_q.push_back({addr, wv});
            else             exp_b_q.push_back({addr, wv});
        end
        for (int i = 0; i < 4; i++) send_byte(sel, wv[31-8*i -: 8], gap);
    endtask

    task automatic pulse_start(input bit sel);
        if (sel == 1'b0) start_a = 1'b1;
        else             start_b = 1'b1;
        sync();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((sel == 1'b0) ? !busy_a : !busy_b) break;
        end
        check(sel ? "b_wait_not_busy" : "a_wait_not_busy", sel ? busy_b : busy_a, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycles %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n            = 1'b0;
        start_a          = 1'b0;
        start_b          = 1'b0;
        bus_a.i_rx_data  = '0;
        bus_a.i_rx_valid = 1'b0;
        bus_b.i_rx_data  = '0;
        bus_b.i_rx_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flag",  bus_a.o_flag_write_intruc, 0);
        check("rst_addr",  bus_a.o_instruction_address, 0);
        check("rst_instr", bus_a.o_instruction, 0);
        check("rst_busy",  busy_a, 0);
        check("rst_done",  done_a, 0);
        check("rst_wc",    wc_a, 0);
        check("rst_ovf",   ovf_b, 0);
        check("rst_tmo",   tmo_a, 0);
        check("rst_state", st_a, IDLE);
        rst_n = 1'b1;
        sync();

        // Normal load with irregular byte gaps
        pulse_start(0);
        @(negedge clk);
        check("norm_busy_after_start", busy_a, 1);
        sync();
        send_word(0, 32'h2001_0005, 32'd0, $urandom_range(0, 2), 1'b1);
        send_word(0, 32'hFFFF_FFFF, 32'd4, $urandom_range(0, 2), 1'b1);
        wait_idle(0, 20);
        check("norm_done",  done_a, 1);
        check("norm_wc",    wc_a, 2);
        check("norm_ovf",   ovf_a, 0);
        check("norm_state", st_a, DONE);

        // Bytes after DONE are dropped
        sync();
        send_word(0, 32'h1234_5678, 32'd0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("done_drop_wc",   wc_a, 2);
        check("done_drop_done", done_a, 1);

        // Back-to-back bytes, 3 words plus HALT
        sync();
        pulse_start(0);
        @(negedge clk);
        check("b2b_done_cleared", done_a, 0);
        check("b2b_wc_cleared",   wc_a, 0);
        sync();
        spacing_en = 1'b1;
        have_last  = 1'b0;
        send_word(0, 32'h1122_3344, 32'd0,  0, 1'b1);
        send_word(0, 32'h5566_7788, 32'd4,  0, 1'b1);
        send_word(0, 32'h99AA_BBCC, 32'd8,  0, 1'b1);
        send_word(0, 32'hFFFF_FFFF, 32'd12, 0, 1'b1);
        wait_idle(0, 20);
        spacing_en = 1'b0;
        check("b2b_wc",   wc_a, 4);
        check("b2b_done", done_a, 1);

        // Start pulsed while in RECV is ignored
        sync();
        pulse_start(0);
        exp_a_q.push_back({32'd0, 32'hDEAD_BEEF});
        send_byte(0, 8'hDE, 1);
        pulse_start(0);
        @(negedge clk);
        check("ign_busy", busy_a, 1);
        sync();
        send_byte(0, 8'hAD, 0);
        send_byte(0, 8'hBE, 1);
        send_byte(0, 8'hEF, 0);
        send_word(0, 32'hFFFF_FFFF, 32'd4, 1, 1'b1);
        wait_idle(0, 20);
        check("ign_wc",   wc_a, 2);
        check("ign_done", done_a, 1);

        // Reset mid-word
        sync();
        pulse_start(0);
        send_word(0, 32'h0102_0304, 32'd0, 0, 1'b1);
        send_byte(0, 8'hAA, 0);
        send_byte(0, 8'hBB, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  busy_a, 0);
        check("mid_rst_wc",    wc_a, 0);
        check("mid_rst_addr",  bus_a.o_instruction_address, 0);
        check("mid_rst_instr", bus_a.o_instruction, 0);
        check("mid_rst_state", st_a, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        pulse_start(0);
        send_word(0, 32'h0A0B_0C0D, 32'd0, 0, 1'b1);
        send_word(0, 32'hFFFF_FFFF, 32'd4, 0, 1'b1);
        wait_idle(0, 20);
        check("post_rst_wc",   wc_a, 2);
        check("post_rst_done", done_a, 1);

        // Overflow on the 16-byte instance
        sync();
        pulse_start(1);
        for (int k = 0; k < 4; k++) send_word(1, 32'h0, 32'(4 * k), 0, 1'b1);
        wait_idle(1, 20);
        check("ovf_flag", ovf_b, 1);
        check("ovf_done", done_b, 0);
        check("ovf_wc",   wc_b, 4);
        check("ovf_state", st_b, ERROR);
        sync();
        send_word(1, 32'h0, 32'd0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("ovf_no_5th_wc", wc_b, 4);
        check("ovf_sticky",    ovf_b, 1);

        // Stalled stream on the 16-byte instance
        sync();
        pulse_start(1);
        @(negedge clk);
        check("tmo_ovf_cleared", ovf_b, 0);
        sync();
        send_byte(1, 8'h11, 0);
        send_byte(1, 8'h22, 0);
`ifdef LOADER_TIMEOUT_EN
        repeat (49) @(posedge clk);
        @(negedge clk);
        check("tmo_not_yet", tmo_b, 0);
        @(negedge clk);
        check("tmo_flag",  tmo_b, 1);
        check("tmo_busy",  busy_b, 0);
        check("tmo_wc",    wc_b, 0);
        check("tmo_state", st_b, ERROR);
`else
        repeat (60) @(negedge clk);
        check("notmo_flag",  tmo_b, 0);
        check("notmo_busy",  busy_b, 1);
        check("notmo_state", st_b, RECV);
`endif

        check("a_queue_empty", 64'(exp_a_q.size()), 0);
        check("b_queue_empty", 64'(exp_b_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Front-end loader that fills instruction memory before the pipeline runs. It takes a byte stream from the UART receiver and assembles it big-endian into 32-bit instructions. It drives the instruction-memory write port of the fetch stage (`i_instruction_address`, `i_instruction`, `i_flag_write_intruc`) one word at a time. Loading stops at the HALT instruction, which is also written, or at memory full.

## Interface
- `BITS_SIZE`, 32, instruction/address width
- `SIZE_TOTAL`, 256, instruction memory size in bytes (multiple of 4; 64 words)
- `HALT_INSTR`, 32'hFFFFFFFF, end-of-program marker
- `TIMEOUT_CYCLES`, 1000000, idle limit between bytes (used only with the timeout macro)

Ports:
- `i_clk` in 1 — clock, rising edge
- `i_reset` in 1 — reset, **asynchronous, active-low**
- `i_start` in 1 — single-cycle pulse, begin a load
- `i_rx_data` in 8 — received byte
- `i_rx_valid` in 1 — one-cycle strobe, `i_rx_data` valid
- `o_instruction_address` out BITS_SIZE — byte address for the write
- `o_instruction` out BITS_SIZE — assembled instruction
- `o_flag_write_intruc` out 1 — write strobe to instruction memory
- `o_busy` out 1 — high in RECV or WRITE
- `o_load_done` out 1 — HALT written, sticky
- `o_overflow_err` out 1 — memory filled without HALT, sticky
- `o_timeout_err` out 1 — stalled stream; tied 0 without the macro
- `o_word_count` out $clog2(SIZE_TOTAL/4)+1 — words written in the current load

## Operation
- States:
  - **IDLE** — after reset.
  - **RECV** — collecting bytes.
  - **WRITE** — one-cycle memory write.
  - **DONE** — HALT written; `o_load_done` high.
  - **ERROR** — `o_overflow_err` and/or `o_timeout_err` high.
- **IDLE/DONE/ERROR + `i_start`** → RECV.
  - Clears address, byte counter, `o_word_count` and all status flags.
- **`i_start` in RECV/WRITE** is ignored.
- **RECV, `i_rx_valid`:**
  - Assembly reg ← {assembly[23:0], `i_rx_data`}; byte_cnt++. The first byte received lands in bits [31:24].
  - On the 4th byte → WRITE.
- **WRITE:**
  - `o_flag_write_intruc`=1 with the current address and word; `o_word_count`++.
  - Word == `HALT_INSTR` → DONE.
  - Else address == `SIZE_TOTAL`-4 → ERROR (overflow).
  - Else address += 4 → RECV.
- **Byte arriving in the WRITE cycle:**
  - Accepted as byte 0 of the next word only when the next state is RECV.
  - Otherwise dropped.
- **Bytes in IDLE/DONE/ERROR** are dropped.
- **Reset (any time, including mid-word):**
  - All outputs 0, state IDLE.
  - Address 0, byte_cnt 0, assembly reg 0.
  - The partial word is discarded.
- Address arithmetic is `BITS_SIZE` wide. It never exceeds `SIZE_TOTAL`-4, so no wrap-around.

## Timing
- All outputs are registered.
- `o_flag_write_intruc` rises in the cycle after the edge that accepts the 4th byte and lasts exactly one cycle.
- Address and data are stable during that cycle.
- `o_load_done` / `o_overflow_err` assert in the cycle after the write strobe and hold until `i_start` or reset.
- `o_busy` rises the cycle after `i_start` and falls when DONE/ERROR is entered.
- Sustains one byte per cycle with no loss: 4 bytes per word, plus the WRITE cycle overlapping the next byte.
- Minimum 4 cycles per word.

## Configuration
- **`LOADER_TIMEOUT_EN` defined:**
  - Counter runs in RECV, clearing on each accepted byte and on entry to RECV.
  - At `TIMEOUT_CYCLES` → ERROR with `o_timeout_err`=1.
  - The partial word is discarded, no write occurs, and `o_word_count` is unchanged.
- **Undefined:** no counter; RECV waits indefinitely; `o_timeout_err` is constant 0.

## Structure
- Package `loader_pkg` holds:
  - state enum (IDLE, RECV, WRITE, DONE, ERROR);
  - default `HALT_INSTR` constant;
  - byte-per-word constant (4) and address step (4).
- Sub-module `word_assembler`:
  - 32-bit shift register plus 2-bit byte counter;
  - `word_ready` pulse on the 4th byte;
  - clear input.
- The FSM, address and status logic live in `instruction_loader`.

## Test plan
- **Normal load:** start, then bytes 20 01 00 05 FF FF FF FF.
  - Writes addr 0 = 0x20010005, then addr 4 = 0xFFFFFFFF.
  - `o_load_done`=1, `o_word_count`=2, `o_busy`=0.
- **Overflow:** `SIZE_TOTAL`=16, 16 bytes of 0x00.
  - Four writes to addr 0, 4, 8, 12, then `o_overflow_err`=1.
  - Further bytes cause no 5th write.
- **Back-to-back:** `i_rx_valid` every cycle for 3 words plus HALT.
  - All 16 bytes land correctly.
  - Write strobes are 4 cycles apart.
- **Reset mid-word:** `i_reset`=0 after 2 bytes.
  - All outputs 0 immediately (asynchronous).
  - After release, start plus 8 bytes writes addr 0 with no stale bytes.
- **Start ignored:** `i_start` pulsed while in RECV with 1 byte held.
  - Load continues; the first write has the correct word at addr 0.
- **Timeout (`LOADER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=50):** 2 bytes then silence.
  - `o_timeout_err`=1 after 50 cycles.
  - No write strobe; `o_word_count` unchanged.
